// File: rtl/lsu.sv
// lsu: load/store unit between execute and dmem.
// Takes one RV32I load/store at a time and turns it into word-aligned dmem
// accesses. Sub-word stores are done as read-modify-write. Load data is
// extracted from the word and sign/zero-extended. Misaligned or illegal
// requests get an error response and never reach memory.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready request handshake (ready only while idle)
//   req_we              1 = store, 0 = load
//   req_funct3          RV32I width code (B, H, W, BU, HU)
//   req_addr            byte address
//   req_wdata           right-aligned store data
//   resp_valid          one-cycle completion pulse
//   resp_rdata          extended load result (0 for stores/errors)
//   resp_err            misaligned/illegal request flag
//   mem_we/mem_addr/mem_wdata  word-aligned dmem access
//   mem_rdata           combinational dmem read data of mem_addr
module lsu #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_RMW_RD,
    S_RMW_WR,
    S_RESP
  } state_t;

  state_t state, state_nx;

  // Latched request fields (the load/store direction is carried by the state)
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  // Next values of the registered outputs
  logic              accept;
  logic [ADDR_W-1:0] addr_src;
  logic              req_ready_d;
  logic              resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_d;
  logic              resp_err_d;
  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;

  // Reserved codes, sub-word-unsigned stores and misaligned H/W are illegal
  function automatic logic is_illegal(input logic we, input logic [2:0] f3,
                                      input logic [1:0] a);
    logic ill;
    ill = 1'b0;
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ill = 1'b1;
    if (we && f3[2])                                  ill = 1'b1;
    if (f3[1:0] == 2'b01 && a[0])                     ill = 1'b1;
    if (f3 == 3'b010 && a != 2'b00)                   ill = 1'b1;
    return ill;
  endfunction

  // Select the addressed lane of a word and extend it per funct3
  function automatic logic [DATA_W-1:0] load_extract(input logic [DATA_W-1:0] w,
                                                     input logic [2:0] f3,
                                                     input logic [1:0] a);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace the addressed byte (SB) or halfword (SH) of the old word
  function automatic logic [DATA_W-1:0] store_merge(input logic [DATA_W-1:0] old,
                                                    input logic [DATA_W-1:0] wd,
                                                    input logic [2:0] f3,
                                                    input logic [1:0] a);
    logic [DATA_W-1:0] r;
    r = old;
    if (f3[0] == 1'b0) begin
      case (a)
        2'd0:    r[7:0]   = wd[7:0];
        2'd1:    r[15:8]  = wd[7:0];
        2'd2:    r[23:16] = wd[7:0];
        default: r[31:24] = wd[7:0];
      endcase
    end else if (a[1]) begin
      r[31:16] = wd[15:0];
    end else begin
      r[15:0] = wd[15:0];
    end
    return r;
  endfunction

  // State register, request latch and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      funct3_q   <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state      <= state_nx;
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_rdata <= resp_rdata_d;
      resp_err   <= resp_err_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      if (accept) begin
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
    end
  end

  // Next state; outputs are derived from the state being entered
  always_comb begin
    state_nx     = state;
    accept       = 1'b0;
    addr_src     = addr_q;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
    mem_wdata_d  = '0;

    case (state)
      S_IDLE: begin
        if (req_valid) begin
          accept   = 1'b1;
          addr_src = req_addr;
          if (is_illegal(req_we, req_funct3, req_addr[1:0])) begin
            state_nx   = S_RESP;
            resp_err_d = 1'b1;
          end else if (!req_we) begin
            state_nx = S_LOAD;
          end else if (req_funct3 == 3'b010) begin
            state_nx    = S_WRITE;
            mem_wdata_d = req_wdata;
          end else begin
            state_nx = S_RMW_RD;
          end
        end
      end
      S_LOAD: begin
        resp_rdata_d = load_extract(mem_rdata, funct3_q, addr_q[1:0]);
        state_nx     = S_RESP;
      end
      S_WRITE: state_nx = S_RESP;
      S_RMW_RD: begin
        // Merged word goes straight into the mem_wdata register for RMW_WR
        mem_wdata_d = store_merge(mem_rdata, wdata_q, funct3_q, addr_q[1:0]);
        state_nx    = S_RMW_WR;
      end
      S_RMW_WR: state_nx = S_RESP;
      S_RESP:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase

    req_ready_d  = (state_nx == S_IDLE);
    resp_valid_d = (state_nx == S_RESP);
    mem_we_d     = (state_nx == S_WRITE) || (state_nx == S_RMW_WR);
    mem_addr_d   = '0;
    if (state_nx == S_LOAD || state_nx == S_WRITE ||
        state_nx == S_RMW_RD || state_nx == S_RMW_WR) begin
      mem_addr_d = {addr_src[ADDR_W-1:2], 2'b00};
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: self-checking bench for lsu. A small word memory stands in for
// dmem; a separate byte-level reference model predicts responses and
// memory contents from the RV32I load/store rules.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] dmem    [16];
  logic [31:0] ref_mem [16];

  int n_tests = 0;
  int n_fail  = 0;

  lsu #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // dmem stand-in: combinational read, synchronous word write
  assign mem_rdata = dmem[mem_addr[5:2]];
  always @(posedge clk) begin
    if (mem_we) dmem[mem_addr[5:2]] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int ref_size(input int f3);
    case (f3)
      0, 4:    return 1;
      1, 5:    return 2;
      2:       return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit ref_illegal(input bit we, input int f3, input int addr);
    int sz;
    sz = ref_size(f3);
    if (sz == 0) return 1'b1;
    if (we && f3 >= 4) return 1'b1;
    return (addr % sz) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input int f3, input int addr);
    logic [31:0] v;
    v = ref_mem[(addr / 4) % 16] >> (8 * (addr % 4));
    if (ref_size(f3) == 1) begin
      v = v & 32'hFF;
      if (f3 == 0 && v >= 32'd128) v = v - 32'd256;
    end else if (ref_size(f3) == 2) begin
      v = v & 32'hFFFF;
      if (f3 == 1 && v >= 32'd32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  task automatic ref_store(input int f3, input int addr, input logic [31:0] wd);
    logic [31:0] mask;
    int          sh;
    int          idx;
    idx  = (addr / 4) % 16;
    sh   = 8 * (addr % 4);
    mask = (ref_size(f3) == 1) ? 32'hFF : (ref_size(f3) == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
    ref_mem[idx] = (ref_mem[idx] & ~(mask << sh)) | ((wd & mask) << sh);
  endtask

  // One request from idle to the idle cycle after its response
  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd);
    bit          ill;
    int          exp_lat;
    int          exp_we_cyc;
    int          we_cnt;
    bit          got;
    logic [31:0] exp_rd;
    logic [31:0] exp_word;
    ill        = ref_illegal(we, int'(f3), int'(addr));
    exp_rd     = 32'd0;
    exp_word   = 32'd0;
    exp_we_cyc = 0;
    if (ill) begin
      exp_lat = 1;
    end else if (!we) begin
      exp_lat = 2;
      exp_rd  = ref_load(int'(f3), int'(addr));
    end else begin
      exp_lat    = (f3 == 3'b010) ? 2 : 3;
      exp_we_cyc = exp_lat - 1;
      ref_store(int'(f3), int'(addr), wd);
      exp_word = ref_mem[(addr / 4) % 16];
    end
    rd = 32'd0;

    @(negedge clk);
    check("ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    // Scramble the request lines; they must be ignored while busy
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    we_cnt = 0;
    got    = 1'b0;
    for (int c = 1; c <= 8 && !got; c++) begin
      if (mem_we) begin
        we_cnt++;
        check("we_cycle", 32'(c), 32'(exp_we_cyc));
        check("mem_addr", mem_addr, {addr[31:2], 2'b00});
        check("mem_wdata", mem_wdata, exp_word);
      end
      if (resp_valid) begin
        got = 1'b1;
        check("resp_latency", 32'(c), 32'(exp_lat));
        check("resp_rdata", resp_rdata, exp_rd);
        check("resp_err", 32'(resp_err), 32'(ill));
        check("ready_in_resp", 32'(req_ready), 32'd0);
        rd = resp_rdata;
      end else begin
        check("busy_ready", 32'(req_ready), 32'd0);
        check("idle_rdata", resp_rdata, 32'd0);
        check("idle_err", 32'(resp_err), 32'd0);
      end
      @(posedge clk);
      #1;
    end
    if (!got) check("resp_timeout", 32'd0, 32'd1);
    check("we_pulses", 32'(we_cnt), (exp_we_cyc > 0) ? 32'd1 : 32'd0);
    check("resp_one_cycle", 32'(resp_valid), 32'd0);
  endtask

  logic [31:0] r;

  initial begin
    int acc_cnt;
    int acc2;
    int resp1;
    int resp2;
    logic [31:0] lw_data;
    bit acc;

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    for (int i = 0; i < 16; i++) begin
      dmem[i]    = $urandom;
      ref_mem[i] = dmem[i];
    end
    #12;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Word store then load
    do_req(1'b1, 3'b010, 32'd0, 32'hADCEAFCD, r);
    do_req(1'b0, 3'b010, 32'd0, 32'd0, r);
    check("lw_addr0", r, 32'hADCEAFCD);

    // Byte read-modify-write
    do_req(1'b1, 3'b010, 32'd4, 32'hDECFECDA, r);
    do_req(1'b1, 3'b000, 32'd5, 32'h0000007F, r);
    check("sb_merged_word", dmem[1], 32'hDECF7FDA);

    // Extension
    do_req(1'b1, 3'b010, 32'd4, 32'hDECFECDA, r);
    do_req(1'b0, 3'b000, 32'd6, 32'd0, r);
    check("lb_6", r, 32'hFFFFFFCF);
    do_req(1'b0, 3'b100, 32'd6, 32'd0, r);
    check("lbu_6", r, 32'h000000CF);
    do_req(1'b0, 3'b001, 32'd6, 32'd0, r);
    check("lh_6", r, 32'hFFFFDECF);
    do_req(1'b0, 3'b101, 32'd6, 32'd0, r);
    check("lhu_6", r, 32'h0000DECF);

    // Errors
    do_req(1'b0, 3'b010, 32'd2, 32'd0, r);
    check("lw_misaligned_rdata", r, 32'd0);
    do_req(1'b1, 3'b001, 32'd3, 32'h1234, r);
    check("sh_misaligned_word", dmem[0], 32'hADCEAFCD);
    do_req(1'b0, 3'b011, 32'd0, 32'd0, r);
    check("f3_011_rdata", r, 32'd0);

    // Back-to-back: SW then LW with req_valid held high
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'd8;
    req_wdata  = 32'h5A5AC3C3;
    ref_store(2, 8, 32'h5A5AC3C3);
    acc_cnt = 0;
    acc2    = -1;
    resp1   = -1;
    resp2   = -1;
    lw_data = 32'd0;
    for (int k = 0; k < 16; k++) begin
      acc = req_valid && req_ready;
      if (resp_valid) begin
        if (resp1 < 0) resp1 = k;
        else begin
          resp2   = k;
          lw_data = resp_rdata;
        end
      end
      @(posedge clk);
      #1;
      if (acc) begin
        acc_cnt++;
        if (acc_cnt == 1) begin
          req_we     = 1'b0;
          req_funct3 = 3'b010;
          req_addr   = 32'd8;
        end else begin
          acc2      = k;
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    check("b2b_first_resp", 32'(resp1), 32'd2);
    check("b2b_second_accept", 32'(acc2), 32'(resp1 + 1));
    check("b2b_second_resp", 32'(resp2), 32'(acc2 + 2));
    check("b2b_lw_data", lw_data, 32'h5A5AC3C3);

    // Randomized traffic against the reference model
    for (int t = 0; t < 300; t++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) a = a & ~32'd3;
      do_req(1'($urandom), 3'($urandom), a, $urandom, r);
    end
    for (int i = 0; i < 16; i++) check("mem_final", dmem[i], ref_mem[i]);

    // Reset during RMW_RD of an SB: no write, no response
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'd13;
    req_wdata  = 32'h000000EE;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("abort_mem_we", 32'(mem_we), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("abort_we_hold", 32'(mem_we), 32'd0);
      check("abort_no_resp", 32'(resp_valid), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", 32'(req_ready), 32'd1);
    check("post_rst_resp", 32'(resp_valid), 32'd0);
    check("abort_mem_intact", dmem[3], ref_mem[3]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
